// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared constants and helpers for the CPU memory-port arbiter.
// Arbitration mode selectors plus a clog2 that never returns 0.
package cpu_mem_arbiter_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_mem_id_fifo.sv
// In-order FIFO of issuing-channel IDs for accepted, unanswered transactions.
// Depth is the outstanding limit; count doubles as the outstanding counter.
module cpu_mem_id_fifo
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 4,
    localparam int PW   = min1_clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_id,
    input  logic          pop,
    output logic [W-1:0]  head_id,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head_id = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop)
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// N-channel SRAM-like arbiter onto one shared memory port with up to MAX_OUTST
// in-order outstanding transactions; responses are routed back via an ID FIFO.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4,
    parameter int PRIO_MODE = ARB_FIXED,
    localparam int BE_W     = DATA_W / 8,
    localparam int CNT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        m_req,
    input  logic [NUM_CH*BE_W-1:0]   m_we,
    input  logic [NUM_CH*ADDR_W-1:0] m_addr,
    input  logic [NUM_CH*DATA_W-1:0] m_wdata,
    output logic [NUM_CH-1:0]        m_addr_ok,
    output logic [NUM_CH-1:0]        m_data_ok,
    output logic [DATA_W-1:0]        m_rdata,
    output logic                     s_req,
    output logic [BE_W-1:0]          s_we,
    output logic [ADDR_W-1:0]        s_addr,
    output logic [DATA_W-1:0]        s_wdata,
    input  logic                     s_addr_ok,
    input  logic                     s_data_ok,
    input  logic [DATA_W-1:0]        s_rdata,
    output logic [CNT_W-1:0]         outst_cnt,
    output logic                     err_unexp
);

    localparam int IDW = min1_clog2(NUM_CH);

    logic             full, empty, accept, pop;
    logic [CNT_W-1:0] cnt;
    logic [IDW-1:0]   head_id;
    logic             grant_vld, lock_hold;
    logic [IDW-1:0]   grant_id;
    logic             lock_q, lock_d;
    logic [IDW-1:0]   lock_ch_q, lock_ch_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             err_q, err_d;

    assign lock_hold = lock_q && m_req[lock_ch_q];

    // A stalled request keeps its grant; a dropped locked request falls back to normal arbitration.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        if (!rst && !full) begin
            if (lock_hold) begin
                grant_vld = 1'b1;
                grant_id  = lock_ch_q;
            end else if (PRIO_MODE == ARB_FIXED) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (m_req[i]) begin
                        grant_vld = 1'b1;
                        grant_id  = IDW'(i);
                    end
                end
            end else begin
                for (int k = NUM_CH - 1; k >= 0; k--) begin
                    if (m_req[(int'(rr_ptr_q) + k) % NUM_CH]) begin
                        grant_vld = 1'b1;
                        grant_id  = IDW'((int'(rr_ptr_q) + k) % NUM_CH);
                    end
                end
            end
        end
    end

    assign s_req  = grant_vld;
    assign accept = s_req && s_addr_ok;
    assign pop    = !rst && s_data_ok && !empty;

    always_comb begin
        s_we      = '0;
        s_addr    = '0;
        s_wdata   = '0;
        m_addr_ok = '0;
        m_data_ok = '0;
        if (s_req) begin
            s_we    = m_we[int'(grant_id)*BE_W +: BE_W];
            s_addr  = m_addr[int'(grant_id)*ADDR_W +: ADDR_W];
            s_wdata = m_wdata[int'(grant_id)*DATA_W +: DATA_W];
            m_addr_ok[grant_id] = s_addr_ok;
        end
        if (pop)
            m_data_ok[head_id] = 1'b1;
        m_rdata   = rst ? '0 : s_rdata;
        outst_cnt = rst ? '0 : cnt;
        err_unexp = err_q && !rst;
    end

    always_comb begin
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        rr_ptr_d  = rr_ptr_q;
        err_d     = err_q | (s_data_ok && empty);
        if (s_req) begin
            lock_d    = !s_addr_ok;
            lock_ch_d = grant_id;
        end else if (!lock_hold) begin
            lock_d = 1'b0;
        end
        if (accept)
            rr_ptr_d = (grant_id == IDW'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
            rr_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
            rr_ptr_q  <= rr_ptr_d;
            err_q     <= err_d;
        end
    end

    cpu_mem_id_fifo #(
        .W     (IDW),
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .push_id (grant_id),
        .pop     (pop),
        .head_id (head_id),
        .full    (full),
        .empty   (empty),
        .count   (cnt)
    );

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench: a fixed-priority instance driven by a cycle-by-cycle vector table,
// plus a round-robin instance checked by a short hand-written sequence.
module tb_cpu_mem_arbiter;
    import cpu_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req;
    logic [7:0]  m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;

    logic [1:0]  f_addr_ok, f_data_ok;
    logic [31:0] f_rdata, f_saddr, f_swdata;
    logic        f_sreq, f_err;
    logic [3:0]  f_swe;
    logic [2:0]  f_cnt;

    logic [1:0]  r_addr_ok, r_data_ok;
    logic [31:0] r_rdata, r_saddr, r_swdata;
    logic        r_sreq, r_err;
    logic [3:0]  r_swe;
    logic [2:0]  r_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.PRIO_MODE(ARB_FIXED)) u_fix (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(f_addr_ok), .m_data_ok(f_data_ok), .m_rdata(f_rdata),
        .s_req(f_sreq), .s_we(f_swe), .s_addr(f_saddr), .s_wdata(f_swdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outst_cnt(f_cnt), .err_unexp(f_err)
    );

    cpu_mem_arbiter #(.PRIO_MODE(ARB_RR)) u_rr (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(r_addr_ok), .m_data_ok(r_data_ok), .m_rdata(r_rdata),
        .s_req(r_sreq), .s_we(r_swe), .s_addr(r_saddr), .s_wdata(r_swdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outst_cnt(r_cnt), .err_unexp(r_err)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic [1:0]  e_aok;
        logic        e_sreq;
        logic [31:0] e_saddr;
        logic [1:0]  e_dok;
        logic [31:0] e_rdata;
        logic [2:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vt[$];

    localparam logic [31:0] A0 = 32'h200;
    localparam logic [31:0] A1 = 32'h100;

    function automatic vec_t mk(input logic r, input logic [1:0] req, input logic aok, input logic dok,
                                input logic [31:0] rd, input logic [1:0] e_aok, input logic e_sreq,
                                input logic [31:0] e_saddr, input logic [1:0] e_dok,
                                input logic [2:0] e_cnt, input logic e_err);
        vec_t v;
        v.rst = r; v.req = req; v.aok = aok; v.dok = dok; v.rdata = rd;
        v.e_aok = e_aok; v.e_sreq = e_sreq; v.e_saddr = e_saddr; v.e_dok = e_dok;
        v.e_rdata = r ? 32'h0 : rd; v.e_cnt = e_cnt; v.e_err = e_err;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [1:0] req, input logic aok, input logic dok,
                         input logic [31:0] rd);
        rst = r; m_req = req; s_addr_ok = aok; s_data_ok = dok; s_rdata = rd;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        drive(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
        m_we    = 8'h00;
        m_addr  = {A1, A0};
        m_wdata = {32'hB1B1_B1B1, 32'hA0A0_A0A0};

        // reset / fixed priority / routing
        vt.push_back(mk(1, 2'b11, 1, 1, 32'hDD, 2'b00, 0, 0,  2'b00, 0, 0));
        vt.push_back(mk(0, 2'b11, 1, 0, 32'h0,  2'b10, 1, A1, 2'b00, 0, 0));
        vt.push_back(mk(0, 2'b01, 1, 0, 32'h0,  2'b01, 1, A0, 2'b00, 1, 0));
        vt.push_back(mk(0, 2'b00, 0, 1, 32'hAA, 2'b00, 0, 0,  2'b10, 2, 0));
        vt.push_back(mk(0, 2'b00, 0, 1, 32'hBB, 2'b00, 0, 0,  2'b01, 1, 0));
        vt.push_back(mk(0, 2'b00, 0, 0, 32'h0,  2'b00, 0, 0,  2'b00, 0, 0));
        // lock held against higher-priority ch1
        vt.push_back(mk(0, 2'b01, 0, 0, 32'h0,  2'b00, 1, A0, 2'b00, 0, 0));
        vt.push_back(mk(0, 2'b11, 0, 0, 32'h0,  2'b00, 1, A0, 2'b00, 0, 0));
        vt.push_back(mk(0, 2'b11, 0, 0, 32'h0,  2'b00, 1, A0, 2'b00, 0, 0));
        vt.push_back(mk(0, 2'b11, 1, 0, 32'h0,  2'b01, 1, A0, 2'b00, 0, 0));
        // fill to MAX_OUTST, full blocks even with same-cycle pop
        vt.push_back(mk(0, 2'b10, 1, 0, 32'h0,  2'b10, 1, A1, 2'b00, 1, 0));
        vt.push_back(mk(0, 2'b11, 1, 0, 32'h0,  2'b10, 1, A1, 2'b00, 2, 0));
        vt.push_back(mk(0, 2'b11, 1, 0, 32'h0,  2'b10, 1, A1, 2'b00, 3, 0));
        vt.push_back(mk(0, 2'b11, 1, 0, 32'h0,  2'b00, 0, 0,  2'b00, 4, 0));
        vt.push_back(mk(0, 2'b11, 1, 1, 32'h11, 2'b00, 0, 0,  2'b01, 4, 0));
        vt.push_back(mk(0, 2'b11, 1, 0, 32'h0,  2'b10, 1, A1, 2'b00, 3, 0));
        vt.push_back(mk(0, 2'b00, 0, 1, 32'h22, 2'b00, 0, 0,  2'b10, 4, 0));
        vt.push_back(mk(0, 2'b00, 0, 1, 32'h23, 2'b00, 0, 0,  2'b10, 3, 0));
        vt.push_back(mk(0, 2'b00, 0, 1, 32'h24, 2'b00, 0, 0,  2'b10, 2, 0));
        vt.push_back(mk(0, 2'b00, 0, 1, 32'h25, 2'b00, 0, 0,  2'b10, 1, 0));
        // unexpected response sets sticky error
        vt.push_back(mk(0, 2'b00, 0, 1, 32'h26, 2'b00, 0, 0,  2'b00, 0, 0));
        vt.push_back(mk(0, 2'b00, 0, 0, 32'h0,  2'b00, 0, 0,  2'b00, 0, 1));
        // simultaneous push and pop
        vt.push_back(mk(0, 2'b01, 1, 0, 32'h0,  2'b01, 1, A0, 2'b00, 0, 1));
        vt.push_back(mk(0, 2'b01, 1, 1, 32'h33, 2'b01, 1, A0, 2'b01, 1, 1));
        vt.push_back(mk(0, 2'b00, 0, 0, 32'h0,  2'b00, 0, 0,  2'b00, 1, 1));
        // reset with outstanding work
        vt.push_back(mk(0, 2'b01, 1, 0, 32'h0,  2'b01, 1, A0, 2'b00, 1, 1));
        vt.push_back(mk(0, 2'b00, 0, 0, 32'h0,  2'b00, 0, 0,  2'b00, 2, 1));
        vt.push_back(mk(1, 2'b00, 0, 0, 32'h0,  2'b00, 0, 0,  2'b00, 0, 0));
        vt.push_back(mk(0, 2'b00, 0, 0, 32'h0,  2'b00, 0, 0,  2'b00, 0, 0));
        // locked master drops req: lock released, ch1 served
        vt.push_back(mk(0, 2'b01, 0, 0, 32'h0,  2'b00, 1, A0, 2'b00, 0, 0));
        vt.push_back(mk(0, 2'b10, 0, 0, 32'h0,  2'b00, 1, A1, 2'b00, 0, 0));
        vt.push_back(mk(0, 2'b10, 1, 0, 32'h0,  2'b10, 1, A1, 2'b00, 0, 0));
        vt.push_back(mk(0, 2'b00, 0, 1, 32'h44, 2'b00, 0, 0,  2'b10, 1, 0));
        vt.push_back(mk(0, 2'b00, 0, 0, 32'h0,  2'b00, 0, 0,  2'b00, 0, 0));

        @(posedge clk); #1;
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].req, vt[i].aok, vt[i].dok, vt[i].rdata);
            @(negedge clk);
            chk($sformatf("fix_vec%0d", i),
                {f_addr_ok, f_sreq, f_saddr, f_data_ok, f_rdata, f_cnt, f_err},
                {vt[i].e_aok, vt[i].e_sreq, vt[i].e_saddr, vt[i].e_dok, vt[i].e_rdata,
                 vt[i].e_cnt, vt[i].e_err});
            @(posedge clk); #1;
        end

        // round-robin: alternate from ch0, then fill and drain one
        drive(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
        @(negedge clk); chk("rr_g0", {r_addr_ok, r_saddr, r_cnt}, {2'b01, A0, 3'd0});
        @(posedge clk); #1;
        @(negedge clk); chk("rr_g1", {r_addr_ok, r_saddr, r_cnt}, {2'b10, A1, 3'd1});
        @(posedge clk); #1;
        @(negedge clk); chk("rr_g2", {r_addr_ok, r_saddr, r_cnt}, {2'b01, A0, 3'd2});
        @(posedge clk); #1;
        drive(1'b0, 2'b10, 1'b1, 1'b0, 32'h0);
        @(negedge clk); chk("rr_g3", {r_addr_ok, r_saddr, r_cnt}, {2'b10, A1, 3'd3});
        @(posedge clk); #1;
        drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
        @(negedge clk); chk("rr_full", {r_addr_ok, r_sreq, r_cnt}, {2'b00, 1'b0, 3'd4});
        @(posedge clk); #1;
        drive(1'b0, 2'b11, 1'b1, 1'b1, 32'h55);
        @(negedge clk);
        chk("rr_full_pop", {r_addr_ok, r_sreq, r_data_ok, r_rdata, r_cnt},
            {2'b00, 1'b0, 2'b01, 32'h55, 3'd4});
        @(posedge clk); #1;
        drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
        @(negedge clk); chk("rr_after_full", {r_addr_ok, r_sreq, r_cnt}, {2'b01, 1'b1, 3'd3});
        @(posedge clk); #1;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
